// File: rtl/uart_rx_sample_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_sample_timer
//
// Oversampling timer for the UART receiver. It counts oversampling clocks
// within each bit period (edge_count) and bit periods within a frame
// (bit_count). From these counts it decodes the mid-bit sample strobes, the
// bit-end pulse and the frame-done pulse. Prescale (P) and frame length (F) are
// captured when a frame starts and stay fixed until the next start. A start
// with an illegal configuration is refused and flagged on cfg_err.
//
// Optional feature (compile-time macro): UART_RX_TIMER_SAMPLE3_EN
//   defined     : sample_stb[0]/[2] fire at mid-1/mid+1 for 3-sample voting
//   not defined : sample_stb[0]/[2] tied low, only the centre strobe is used
//
// Ports
//   clk            in   oversampling clock
//   rst            in   synchronous, active-high reset
//   prescale       in   oversampling clocks per bit, legal 4..2^PRESCALE_W-1
//   frame_bits     in   bit periods per frame, legal 2..2^BIT_CNT_W-1
//   counter_enable in   level, high while the RX FSM has a frame in progress
//   edge_count     out  edge index within the current bit, 0..P-1
//   bit_count      out  bit index within the frame, 0..F-1
//   sample_stb     out  [1] centre strobe, [0]/[2] centre-1/centre+1
//   bit_end        out  last edge of a bit period
//   frame_done     out  last edge of the last bit of the frame
//   cfg_err        out  the last start attempt used an illegal configuration
// -----------------------------------------------------------------------------
module uart_rx_sample_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    input  logic                  counter_enable,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic [2:0]            sample_stb,
    output logic                  bit_end,
    output logic                  frame_done,
    output logic                  cfg_err
);

    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
    localparam logic [BIT_CNT_W-1:0]  F_MIN = BIT_CNT_W'(2);
    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  F_ONE = BIT_CNT_W'(1);

    // HOLD parks the timer after a completed frame so that an enable still
    // high from that frame cannot start a second, unintended count.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD
    } state_e;

    state_e                  state_q,   state_d;
    logic [PRESCALE_W-1:0]   edge_q,    edge_d;
    logic [BIT_CNT_W-1:0]    bit_q,     bit_d;
    logic [PRESCALE_W-1:0]   p_q,       p_d;
    logic [BIT_CNT_W-1:0]    f_q,       f_d;
    logic                    cfg_err_q, cfg_err_d;

    logic                    counting;
    logic                    last_edge;
    logic                    last_bit;
    logic                    cfg_legal;
    logic [PRESCALE_W-1:0]   mid;

    assign counting  = (state_q == ST_COUNT);
    assign last_edge = (edge_q == p_q - P_ONE);
    assign last_bit  = (bit_q == f_q - F_ONE);
    assign cfg_legal = (prescale >= P_MIN) && (frame_bits >= F_MIN);
    // For P >= 4, mid-1 >= 1 and mid+1 <= P-1, so no strobe index wraps.
    assign mid       = p_q >> 1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        p_d       = p_q;
        f_d       = f_q;
        cfg_err_d = cfg_err_q;

        unique case (state_q)
            ST_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (counter_enable) begin
                    if (cfg_legal) begin
                        p_d       = prescale;
                        f_d       = frame_bits;
                        cfg_err_d = 1'b0;
                        state_d   = ST_COUNT;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_COUNT: begin
                if (!counter_enable) begin
                    // Abort: drop back to IDLE without a frame_done.
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (last_edge) begin
                    edge_d = '0;
                    if (last_bit) begin
                        state_d = ST_HOLD;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + F_ONE;
                    end
                end else begin
                    edge_d = edge_q + P_ONE;
                end
            end

            ST_HOLD: begin
                edge_d = '0;
                bit_d  = '0;
                if (!counter_enable) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the
        // pre-edge values and the update order inside the block is irrelevant.
        if (rst) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_q       <= '0;
            f_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            p_q       <= p_d;
            f_q       <= f_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decodes (same cycle as the count value they qualify)
    // -------------------------------------------------------------------------
    always_comb begin
        sample_stb    = '0;
        sample_stb[1] = counting && (edge_q == mid);
`ifdef UART_RX_TIMER_SAMPLE3_EN
        sample_stb[0] = counting && (edge_q == mid - P_ONE);
        sample_stb[2] = counting && (edge_q == mid + P_ONE);
`else
        sample_stb[0] = 1'b0;
        sample_stb[2] = 1'b0;
`endif
    end

    assign bit_end    = counting && last_edge;
    assign frame_done = bit_end && last_bit;
    assign edge_count = edge_q;
    assign bit_count  = bit_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_sample_timer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sample_timer
//
// Self-checking bench for uart_rx_sample_timer. The reference model describes
// a frame by its start and its cycle index n inside the frame. The expected
// counts follow from that index as edge = n % P and bit = n / P, and the frame
// ends at n = P*F-1. Every clock compares all DUT outputs against the model.
// A short table of explicit vectors and several hand-written corner sequences
// add targeted checks. A long randomized run follows them.
// -----------------------------------------------------------------------------
module tb_uart_rx_sample_timer;

    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = 4;

`ifdef UART_RX_TIMER_SAMPLE3_EN
    localparam logic [2:0] STB_MASK = 3'b111;
    localparam bit         SAMPLE3  = 1'b1;
`else
    localparam logic [2:0] STB_MASK = 3'b010;
    localparam bit         SAMPLE3  = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [PRESCALE_W-1:0] prescale = '0;
    logic [BIT_CNT_W-1:0]  frame_bits = '0;
    logic                  counter_enable = 1'b0;
    logic [PRESCALE_W-1:0] edge_count;
    logic [BIT_CNT_W-1:0]  bit_count;
    logic [2:0]            sample_stb;
    logic                  bit_end;
    logic                  frame_done;
    logic                  cfg_err;

    uart_rx_sample_timer #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .prescale       (prescale),
        .frame_bits     (frame_bits),
        .counter_enable (counter_enable),
        .edge_count     (edge_count),
        .bit_count      (bit_count),
        .sample_stb     (sample_stb),
        .bit_end        (bit_end),
        .frame_done     (frame_done),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = idle, 1 = frame running, 2 = waiting for enable to drop
    int m_mode  = 0;
    int m_n     = 0;
    int m_p     = 0;
    int m_f     = 0;
    int m_err   = 0;
    bit m_valid = 1'b0;

    // DUT outputs as observed in the most recent cycle
    int obs_edge, obs_bit, obs_stb, obs_be, obs_fd, obs_err;

    // One clock: drive inputs, compare outputs mid-cycle, advance model on edge.
    task automatic tick(input bit r, input bit e, input int p, input int f);
        int ex_edge, ex_bit, ex_stb, ex_be, ex_fd, mid;
        rst            = r;
        counter_enable = e;
        prescale       = PRESCALE_W'(p);
        frame_bits     = BIT_CNT_W'(f);
        @(negedge clk);
        obs_edge = int'(edge_count);
        obs_bit  = int'(bit_count);
        obs_stb  = int'(sample_stb);
        obs_be   = int'(bit_end);
        obs_fd   = int'(frame_done);
        obs_err  = int'(cfg_err);
        if (m_valid) begin
            ex_edge = 0; ex_bit = 0; ex_stb = 0; ex_be = 0; ex_fd = 0;
            if (m_mode == 1) begin
                ex_edge = m_n % m_p;
                ex_bit  = m_n / m_p;
                mid     = m_p / 2;
                ex_stb  = ((ex_edge == mid - 1) ? 1 : 0) |
                          ((ex_edge == mid)     ? 2 : 0) |
                          ((ex_edge == mid + 1) ? 4 : 0);
                ex_stb  = ex_stb & int'(STB_MASK);
                ex_be   = (ex_edge == m_p - 1) ? 1 : 0;
                ex_fd   = (m_n == m_p * m_f - 1) ? 1 : 0;
            end
            check("edge_count", obs_edge, ex_edge);
            check("bit_count",  obs_bit,  ex_bit);
            check("sample_stb", obs_stb,  ex_stb);
            check("bit_end",    obs_be,   ex_be);
            check("frame_done", obs_fd,   ex_fd);
            check("cfg_err",    obs_err,  m_err);
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_mode  = 0;
            m_err   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_mode)
                0: if (e) begin
                    if (p >= 4 && f >= 2) begin
                        m_mode = 1; m_n = 0; m_p = p; m_f = f; m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                1: begin
                    if (!e)                       m_mode = 0;
                    else if (m_n == m_p*m_f - 1)  m_mode = 2;
                    else                          m_n++;
                end
                default: if (!e) m_mode = 0;
            endcase
        end
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 0, 0);
    endtask

    // Runs with enable high until frame_done is seen or the budget expires.
    int first_s0, first_s1, first_s2, first_be, n_s1, n_be;
    task automatic run_until_done(input int p, input int f, input int budget,
                                  output int len);
        first_s0 = -1; first_s1 = -1; first_s2 = -1; first_be = -1;
        n_s1 = 0; n_be = 0; len = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1'b0, 1'b1, p, f);
            if (obs_stb[0] && first_s0 < 0) first_s0 = obs_edge;
            if (obs_stb[2] && first_s2 < 0) first_s2 = obs_edge;
            if (obs_stb[1]) begin
                if (first_s1 < 0) first_s1 = obs_edge;
                n_s1++;
            end
            if (obs_be) begin
                if (first_be < 0) first_be = obs_edge;
                n_be++;
            end
            if (obs_fd) begin
                len = i;
                break;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         en;
        int         p;
        int         f;
        int         e_edge;
        int         e_bit;
        logic [2:0] e_stb;    // full 3-sample pattern, masked for the build
        bit         e_be;
        bit         e_fd;
        bit         e_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int len;

        // Inputs apply in the row's cycle; expectations are outputs in that cycle.
        vecs[0]  = '{0, 1, 3, 2, 0, 0, 3'b000, 0, 0, 0}; // illegal P=3 start
        vecs[1]  = '{0, 0, 4, 2, 0, 0, 3'b000, 0, 0, 1}; // cfg_err now set
        vecs[2]  = '{0, 1, 4, 2, 0, 0, 3'b000, 0, 0, 1}; // legal start P=4 F=2
        vecs[3]  = '{0, 1, 9, 9, 0, 0, 3'b000, 0, 0, 0}; // input change ignored
        vecs[4]  = '{0, 1, 9, 9, 1, 0, 3'b001, 0, 0, 0};
        vecs[5]  = '{0, 1, 9, 9, 2, 0, 3'b010, 0, 0, 0};
        vecs[6]  = '{0, 1, 9, 9, 3, 0, 3'b100, 1, 0, 0};
        vecs[7]  = '{0, 1, 9, 9, 0, 1, 3'b000, 0, 0, 0};
        vecs[8]  = '{0, 1, 9, 9, 1, 1, 3'b001, 0, 0, 0};
        vecs[9]  = '{0, 1, 9, 9, 2, 1, 3'b010, 0, 0, 0};
        vecs[10] = '{0, 1, 9, 9, 3, 1, 3'b100, 1, 1, 0}; // frame_done
        vecs[11] = '{0, 1, 9, 9, 0, 0, 3'b000, 0, 0, 0}; // HOLD, enable stale
        vecs[12] = '{0, 0, 9, 9, 0, 0, 3'b000, 0, 0, 0}; // HOLD -> IDLE
        vecs[13] = '{0, 0, 9, 9, 0, 0, 3'b000, 0, 0, 0};

        do_reset();
        check("reset_edge",  obs_edge, 0);
        check("reset_bit",   obs_bit,  0);
        check("reset_err",   obs_err,  0);

        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].p, vecs[i].f);
            check($sformatf("vec%0d_edge", i), obs_edge, vecs[i].e_edge);
            check($sformatf("vec%0d_bit", i),  obs_bit,  vecs[i].e_bit);
            check($sformatf("vec%0d_stb", i),  obs_stb,  int'(vecs[i].e_stb & STB_MASK));
            check($sformatf("vec%0d_be", i),   obs_be,   int'(vecs[i].e_be));
            check($sformatf("vec%0d_fd", i),   obs_fd,   int'(vecs[i].e_fd));
            check($sformatf("vec%0d_err", i),  obs_err,  int'(vecs[i].e_err));
        end

        // P=16, F=10 with enable held: 160-cycle frame, then HOLD.
        do_reset();
        tick(1'b0, 1'b1, 16, 10);
        run_until_done(16, 10, 400, len);
        check("p16_frame_len", len, 160);
        check("p16_stb1_edge", first_s1, 8);
        check("p16_stb1_cnt",  n_s1, 10);
        check("p16_bitend_cnt", n_be, 10);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 16, 10);
            check("p16_hold_edge", obs_edge, 0);
            check("p16_hold_fd",   obs_fd,   0);
        end
        tick(1'b0, 1'b0, 16, 10);
        tick(1'b0, 1'b0, 16, 10);

        // P=8, F=2 strobe positions.
        tick(1'b0, 1'b1, 8, 2);
        run_until_done(8, 2, 100, len);
        check("p8_frame_len", len, 16);
        check("p8_stb1_edge", first_s1, 4);
        check("p8_stb1_cnt",  n_s1, 2);
        check("p8_stb0_edge", first_s0, SAMPLE3 ? 3 : -1);
        check("p8_stb2_edge", first_s2, SAMPLE3 ? 5 : -1);
        tick(1'b0, 1'b0, 8, 2);

        // P=63 (maximum): strobes at 30/31/32, bit_end at 62.
        tick(1'b0, 1'b1, 63, 2);
        run_until_done(63, 2, 300, len);
        check("p63_frame_len", len, 126);
        check("p63_stb1_edge", first_s1, 31);
        check("p63_stb0_edge", first_s0, SAMPLE3 ? 30 : -1);
        check("p63_stb2_edge", first_s2, SAMPLE3 ? 32 : -1);
        check("p63_bitend_edge", first_be, 62);
        tick(1'b0, 1'b0, 63, 2);

        // Abort at bit_count=4, edge_count=7.
        tick(1'b0, 1'b1, 16, 10);
        for (int i = 0; i < 4*16 + 7; i++) tick(1'b0, 1'b1, 16, 10);
        tick(1'b0, 1'b0, 16, 10);
        check("abort_at_edge", obs_edge, 7);
        check("abort_at_bit",  obs_bit,  4);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 16, 10);
            check("abort_edge", obs_edge, 0);
            check("abort_bit",  obs_bit,  0);
            check("abort_fd",   obs_fd,   0);
        end

        // prescale changed 16 -> 8 mid-frame: this frame stays at 160 cycles.
        tick(1'b0, 1'b1, 16, 10);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 16, 10);
        run_until_done(8, 10, 400, len);
        check("pchg_frame_len", len + 20, 160);
        tick(1'b0, 1'b0, 8, 10);
        tick(1'b0, 1'b1, 8, 10);
        run_until_done(8, 10, 400, len);
        check("pchg_next_len", len, 80);
        tick(1'b0, 1'b0, 8, 10);

        // Illegal prescale, then a legal retry.
        tick(1'b0, 1'b1, 3, 10);
        tick(1'b0, 1'b1, 3, 10);
        check("cfgerr_set",  obs_err,  1);
        check("cfgerr_edge", obs_edge, 0);
        tick(1'b0, 1'b1, 16, 10);
        check("cfgerr_held", obs_err, 1);
        run_until_done(16, 10, 400, len);
        check("cfgerr_retry_len", len, 160);
        check("cfgerr_cleared",   obs_err, 0);
        tick(1'b0, 1'b0, 16, 10);

        // rst at bit_count=5 with enable still high.
        tick(1'b0, 1'b1, 16, 10);
        for (int i = 0; i < 5*16 + 3; i++) tick(1'b0, 1'b1, 16, 10);
        tick(1'b1, 1'b1, 16, 10);
        check("rst_at_bit", obs_bit, 5);
        tick(1'b0, 1'b1, 16, 10);
        check("rst_edge", obs_edge, 0);
        check("rst_bit",  obs_bit,  0);
        check("rst_err",  obs_err,  0);
        run_until_done(16, 10, 400, len);
        check("rst_restart_len", len, 160);
        tick(1'b0, 1'b0, 16, 10);

        // Randomized run against the model.
        begin
            bit en = 1'b0;
            int p = 16;
            int f = 10;
            for (int i = 0; i < 8000; i++) begin
                if ($urandom_range(0, 99) == 0) begin
                    p = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3)
                                                    : $urandom_range(4, 63);
                    f = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1)
                                                    : $urandom_range(2, 15);
                end
                if (en) begin
                    if ($urandom_range(0, 299) == 0) en = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) en = 1'b1;
                end
                tick(($urandom_range(0, 999) == 0), en, p, f);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
